// File: rtl/decode_pkg.sv
// decode_pkg: RV32I opcodes and the enums shared by the decode stage.
package decode_pkg;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_MISC   = 7'h0f;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  typedef enum logic [2:0] {
    CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ALU, CLS_ALU_IMM, CLS_UPPER, CLS_SYSTEM
  } op_class_t;
  // Base codes equal funct3; SUB/SRA are ADD/SR with imm[10] (funct7[5]) set.
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SR, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate for each RV32I format; R-format yields the I-layout so funct7 reaches execute.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm
);
  always_comb
    imm = (fmt == FMT_S) ? {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]} :
          (fmt == FMT_B) ? {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
          (fmt == FMT_U) ? {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0} :
          (fmt == FMT_J) ? {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
                           {{(XLEN-11){instr[31]}}, instr[30:20]};
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode slice with valid/ready, flush and a saturating accept counter.
// Define DECODE_MEXT_EN to decode the M extension (alu_op 8-15); otherwise those encodings are illegal.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_op,
  output logic [2:0]       out_op_class,
  output logic             out_rd_we,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decoded_count
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0] state;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic ill, we, accept;
  fmt_t fmt;
  op_class_t cls;
  alu_op_t alu;
  logic [XLEN-1:0] imm_raw;
  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];
  always_comb begin
    ill = 1'b0;
    fmt = FMT_I;
    cls = CLS_SYSTEM;
    alu = ALU_ADD;
    case (opc)
      OP_LOAD: begin
        cls = CLS_LOAD;
        ill = (f3 == 3'd3) || (f3[2:1] == 2'b11);
      end
      OP_STORE: begin
        cls = CLS_STORE;
        fmt = FMT_S;
        ill = f3 > 3'd2;
      end
      OP_BRANCH: begin
        cls = CLS_BRANCH;
        fmt = FMT_B;
        ill = f3[2:1] == 2'b01;
        alu = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_XOR;
      end
      OP_JAL: begin
        cls = CLS_JUMP;
        fmt = FMT_J;
      end
      OP_JALR: begin
        cls = CLS_JUMP;
        ill = f3 != 3'd0;
      end
      OP_LUI, OP_AUIPC: begin
        cls = CLS_UPPER;
        fmt = FMT_U;
      end
      OP_IMM: begin
        cls = CLS_ALU_IMM;
        alu = alu_op_t'({1'b0, f3});
        ill = ((f3 == 3'd1) && (f7 != 7'h00)) || ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      OP_REG: begin
        cls = CLS_ALU;
        fmt = FMT_R;
        alu = alu_op_t'({1'b0, f3});
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
`ifdef DECODE_MEXT_EN
        if (f7 == 7'h01) begin
          alu = alu_op_t'({1'b1, f3});
          ill = 1'b0;
        end
`endif
      end
      OP_MISC, OP_SYSTEM: ill = 1'b0;
      default: ill = 1'b1;
    endcase
  end
  imm_gen #(.XLEN(XLEN)) u_imm (.instr(in_instr[31:7]), .fmt(fmt), .imm(imm_raw));
  assign we        = !ill && (in_instr[11:7] != 5'd0) && !(cls inside {CLS_STORE, CLS_BRANCH, CLS_SYSTEM});
  assign in_ready  = !flush && ((state == EMPTY) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = state == FULL;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= EMPTY;
      out_pc        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_imm       <= '0;
      out_alu_op    <= '0;
      out_op_class  <= '0;
      out_rd_we     <= 1'b0;
      out_illegal   <= 1'b0;
      decoded_count <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (accept) begin
      state         <= FULL;
      out_pc        <= in_pc;
      out_rs1       <= in_instr[19:15];
      out_rs2       <= in_instr[24:20];
      out_rd        <= in_instr[11:7];
      out_imm       <= ill ? '0 : imm_raw;
      out_alu_op    <= ill ? ALU_ADD : alu;
      out_op_class  <= ill ? CLS_SYSTEM : cls;
      out_rd_we     <= we;
      out_illegal   <= ill;
      if (!(&decoded_count)) decoded_count <= decoded_count + CNT_W'(1);
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, pipelined RV32I instruction decode stage for the CPU core.
- Sits between fetch and execute, with valid/ready handshakes on both sides.
- Decodes one 32-bit instruction per cycle into register indices, a sign-extended immediate (XLEN wide), an ALU op, an op class and a write enable.
- Output is registered: one-entry pipeline slice with a flush input.

Parameters:
- XLEN, 32, datapath width of in_pc, out_pc and out_imm (legal values 32 or 64).
- CNT_W, 16, width of the saturating decoded-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  discard the held instruction (branch redirect).
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  decode stage can accept.
- in_pc  input  XLEN  PC of the instruction.
- in_instr  input  32  raw instruction word.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute accepts the bundle.
- out_pc  output  XLEN  registered PC.
- out_rs1, out_rs2, out_rd  output  5  register indices.
- out_imm  output  XLEN  sign-extended immediate.
- out_alu_op  output  4  ALU operation (package enum).
- out_op_class  output  3  LOAD/STORE/BRANCH/JUMP/ALU/ALU_IMM/UPPER/SYSTEM.
- out_rd_we  output  1  destination register write enable.
- out_illegal  output  1  unrecognised encoding.
- decoded_count  output  CNT_W  count of accepted instructions, saturates at all-ones.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low.
- Reset values: out_valid=0; all data outputs 0; decoded_count=0; state EMPTY.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = (state==EMPTY) || out_ready; forced 0 while flush=1.
- Accept occurs when in_valid && in_ready.
  - On accept: the decoded bundle is registered and visible the next cycle (latency 1). State becomes FULL.
  - decoded_count increments by 1, unless already all-ones.
- FULL with out_ready=1 and no accept: state becomes EMPTY.
- FULL with out_ready=1 and an accept in the same cycle: state stays FULL, bundle is replaced. Full throughput, no bubble.
- FULL with out_ready=0: all outputs are held stable. No change is permitted while out_valid=1 && !out_ready.
- flush=1 (priority over everything except reset):
  - Next state is EMPTY, out_valid=0.
  - No accept that cycle.
  - decoded_count is not decremented.
- Immediates: I/S/B/U/J formats sign-extended from bit 31 to XLEN.
  - U: imm = {instr[31:12], 12'b0}, sign-extended when XLEN=64.
  - B/J: bit 0 = 0.
- Register indices and write enable:
  - rs1, rs2 and rd are always the raw fields, whatever the format.
  - out_rd_we=0 for STORE, BRANCH, SYSTEM, illegal, and any rd==0.
- Illegal encoding:
  - Triggers: opcode outside the RV32I base set, instr[1:0]!=2'b11, or an unsupported funct3/funct7 combination.
  - Response: out_illegal=1, out_rd_we=0, out_alu_op=ADD, out_imm=0.
- Reset mid-operation: the held bundle is dropped immediately; outputs return to reset values.

Optional Feature:
- Macro: DECODE_MEXT_EN.
- Defined: opcode 0x33 with funct7=0000001 decodes to MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, using alu_op codes 8-15. op_class=ALU, rd_we as normal.
- Undefined: those encodings are illegal.

Decomposition:
- Package decode_pkg: opcode constants, op_class enum (3-bit), alu_op enum (4-bit, M-ext codes reserved as 8-15), format enum.
- Sub-module imm_gen: purely combinational; instr and format in, XLEN immediate out, parametrised on XLEN.
- decode_stage holds the state machine, handshake, register slice and counter.

Test Plan:
- ADDI x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, op_class=ALU_IMM, rd_we=1, decoded_count=1.
- ADDI x2,x2,-1 (0xfff10113) with XLEN=32 and XLEN=64 -> imm=0xFFFFFFFF and 0xFFFFFFFFFFFFFFFF respectively.
- LUI x5 (0x123452b7) followed by ADDI x1,x0,5 with out_ready=0 for 3 cycles:
  - LUI bundle (imm=0x12345000, rd=5) is held stable and in_ready=0.
  - After out_ready rises, ADDI is accepted with no bubble.
- Instruction 0x00000000 -> out_illegal=1, rd_we=0, out_valid=1.
- MUL x3,x1,x2 (0x022081b3):
  - With DECODE_MEXT_EN -> alu_op=MUL, rd=3, rd_we=1.
  - Without DECODE_MEXT_EN -> out_illegal=1.
- Stage FULL, then flush=1 together with in_valid=1 -> next cycle out_valid=0, decoded_count unchanged. Also drive rst_n low mid-stream -> outputs are 0 immediately, asynchronously.
